// File: rtl/spram_pkg.sv
// -----------------------------------------------------------------------------
// spram_pkg
// Shared definitions for the lane-masked single-port RAM block:
//   - state_e    : request sequencer states (IDLE, RMW_WRITE)
//   - lane_merge : builds a word from new data on enabled lanes and the
//                  previously stored word on all other lanes
// No ports (package).
// -----------------------------------------------------------------------------
package spram_pkg;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    RMW_WRITE = 1'b1
  } state_e;

  // Upper bounds for the generic merge helper; callers zero-extend into these.
  localparam int MAX_DWIDTH = 512;
  localparam int MAX_LANES  = 64;

  // Lane merge: bit i comes from new_word when the lane containing it
  // (i / lane_width) is enabled in mask, otherwise from old_word.
  function automatic logic [MAX_DWIDTH-1:0] lane_merge(
    input logic [MAX_DWIDTH-1:0] new_word,
    input logic [MAX_DWIDTH-1:0] old_word,
    input logic [MAX_LANES-1:0]  mask,
    input int                    lane_width
  );
    logic [MAX_DWIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_DWIDTH; i++) begin
      if ((lane_width > 0) && ((i / lane_width) < MAX_LANES)) begin
        if (mask[i / lane_width]) begin
          merged[i] = new_word[i];
        end else begin
          merged[i] = old_word[i];
        end
      end else begin
        merged[i] = old_word[i];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/spram_lane_rmw_if.sv
// -----------------------------------------------------------------------------
// spram_lane_rmw_if
// Request/response bundle of spram_lane_rmw.
//   req_valid/req_ready : request handshake (accept = valid & ready)
//   req_wren            : 1 = write, 0 = read
//   req_mask            : per-lane write enables (ignored for reads)
//   req_addr, req_data  : word address and write data
//   rsp_valid, rsp_data : one-cycle read result strobe and held read data
//   busy                : sequencer active or responses still in flight
// Modports: master (requester side), slave (RAM side).
// -----------------------------------------------------------------------------
interface spram_lane_rmw_if #(
  parameter int AWIDTH = 11,
  parameter int DWIDTH = 40,
  parameter int LANES  = 5
);

  logic              req_valid;
  logic              req_ready;
  logic              req_wren;
  logic [LANES-1:0]  req_mask;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_data;
  logic              rsp_valid;
  logic [DWIDTH-1:0] rsp_data;
  logic              busy;

  modport master (
    output req_valid, req_wren, req_mask, req_addr, req_data,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_wren, req_mask, req_addr, req_data,
    output req_ready, rsp_valid, rsp_data, busy
  );

endinterface

// File: rtl/spram_core.sv
// -----------------------------------------------------------------------------
// spram_core
// Storage-only single-port RAM with a registered read port.
//   clk   : clock
//   en    : access enable
//   we    : 1 = write wdata to addr, 0 = read addr into rdata
//   addr  : word address (caller guarantees addr < NUM_WORDS when en)
//   wdata : write data
//   rdata : read data, valid the cycle after a read, held otherwise
// Written as a plain behavioural array so it maps onto a single-port RAM
// macro; contents and the read register are intentionally not reset.
// -----------------------------------------------------------------------------
module spram_core #(
  parameter int AWIDTH    = 11,
  parameter int DWIDTH    = 40,
  parameter int NUM_WORDS = 2048
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem_r [0:NUM_WORDS-1];
  logic [DWIDTH-1:0] rdata_r;

  // Single port: one access per cycle, either a write or a registered read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_r[addr] <= wdata;
      end else begin
        rdata_r <= mem_r[addr];
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/spram_lane_rmw.sv
// -----------------------------------------------------------------------------
// spram_lane_rmw
// Single-port RAM with valid/ready requests, per-lane write masking done via
// an internal read-modify-write sequencer, and OUT_STAGES extra output
// register stages after the array read register.
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : spram_lane_rmw_if.slave (request, response, busy)
// Read latency: accepted in T, rsp_valid in T+1+OUT_STAGES.
// Partial-mask writes spend one extra RMW_WRITE cycle with req_ready low.
// -----------------------------------------------------------------------------
module spram_lane_rmw
  import spram_pkg::*;
#(
  parameter int AWIDTH     = 11,
  parameter int NUM_WORDS  = 2048,
  parameter int DWIDTH     = 40,
  parameter int LANES      = 5,
  parameter int OUT_STAGES = 1
) (
  input  logic           clk,
  input  logic           resetn,
  spram_lane_rmw_if.slave bus
);

  localparam int LW = DWIDTH / LANES;

  // Elaboration-time parameter checks.
  if ((DWIDTH % LANES) != 0) begin : g_bad_lanes
    $error("spram_lane_rmw: DWIDTH must be a multiple of LANES");
  end
  if ((OUT_STAGES < 0) || (OUT_STAGES > 2)) begin : g_bad_stages
    $error("spram_lane_rmw: OUT_STAGES must be 0..2");
  end
  if (NUM_WORDS > (1 << AWIDTH)) begin : g_bad_depth
    $error("spram_lane_rmw: NUM_WORDS exceeds address space");
  end
  if ((DWIDTH > MAX_DWIDTH) || (LANES > MAX_LANES)) begin : g_bad_max
    $error("spram_lane_rmw: DWIDTH/LANES exceed lane_merge limits");
  end

  // Sequencer and merge registers.
  state_e            state_r;
  logic              req_ready_r;
  logic [AWIDTH-1:0] rmw_addr_r;
  logic [DWIDTH-1:0] rmw_data_r;
  logic [LANES-1:0]  rmw_mask_r;
  logic              rmw_oor_r;

  // Array read register stage tracking.
  logic              vld0_r;
  logic              oor0_r;

  // Request decode.
  logic              accept_s;
  logic              in_range_s;
  logic              mask_full_s;
  logic              mask_none_s;
  logic              rd_issue_s;
  logic              rmw_start_s;

  // Core port.
  logic              core_en_s;
  logic              core_we_s;
  logic [AWIDTH-1:0] core_addr_s;
  logic [DWIDTH-1:0] core_wdata_s;
  logic [DWIDTH-1:0] core_rdata_s;
  logic [DWIDTH-1:0] merged_s;
  logic [DWIDTH-1:0] s0_data_s;

  assign accept_s    = bus.req_valid & req_ready_r;
  assign in_range_s  = (32'(bus.req_addr) < NUM_WORDS);
  assign mask_full_s = (bus.req_mask == {LANES{1'b1}});
  assign mask_none_s = (bus.req_mask == {LANES{1'b0}});
  assign rd_issue_s  = accept_s & ~bus.req_wren;
  assign rmw_start_s = accept_s & bus.req_wren & ~mask_full_s & ~mask_none_s;

  // Latched data on enabled lanes, freshly read word everywhere else.
  assign merged_s = DWIDTH'(lane_merge(MAX_DWIDTH'(rmw_data_r),
                                       MAX_DWIDTH'(core_rdata_s),
                                       MAX_LANES'(rmw_mask_r), LW));

  // Out-of-range reads never touch the array; the stage forces zeros instead.
  assign s0_data_s = oor0_r ? {DWIDTH{1'b0}} : core_rdata_s;

  // Array access select: RMW write-back has priority, else decode the request.
  always_comb begin
    core_en_s    = 1'b0;
    core_we_s    = 1'b0;
    core_addr_s  = bus.req_addr;
    core_wdata_s = bus.req_data;
    if (state_r == RMW_WRITE) begin
      core_en_s    = ~rmw_oor_r;
      core_we_s    = 1'b1;
      core_addr_s  = rmw_addr_r;
      core_wdata_s = merged_s;
    end else if (accept_s && in_range_s) begin
      if (!bus.req_wren) begin
        core_en_s = 1'b1;
      end else if (mask_full_s) begin
        core_en_s = 1'b1;
        core_we_s = 1'b1;
      end else if (!mask_none_s) begin
        // Partial write: read the old word now, merge next cycle.
        core_en_s = 1'b1;
      end else begin
        core_en_s = 1'b0;
      end
    end else begin
      core_en_s = 1'b0;
    end
  end

  spram_core #(
    .AWIDTH    (AWIDTH),
    .DWIDTH    (DWIDTH),
    .NUM_WORDS (NUM_WORDS)
  ) u_core (
    .clk   (clk),
    .en    (core_en_s),
    .we    (core_we_s),
    .addr  (core_addr_s),
    .wdata (core_wdata_s),
    .rdata (core_rdata_s)
  );

  // Request sequencer: IDLE accepts, RMW_WRITE spends one cycle writing back.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b1;
      rmw_addr_r  <= {AWIDTH{1'b0}};
      rmw_data_r  <= {DWIDTH{1'b0}};
      rmw_mask_r  <= {LANES{1'b0}};
      rmw_oor_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (rmw_start_s) begin
            state_r     <= RMW_WRITE;
            req_ready_r <= 1'b0;
            rmw_addr_r  <= bus.req_addr;
            rmw_data_r  <= bus.req_data;
            rmw_mask_r  <= bus.req_mask;
            rmw_oor_r   <= ~in_range_s;
          end
        end
        RMW_WRITE: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Tracks which array-register cycles carry a read result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld0_r <= 1'b0;
      oor0_r <= 1'b0;
    end else begin
      vld0_r <= rd_issue_s;
      oor0_r <= rd_issue_s & ~in_range_s;
    end
  end

  assign bus.req_ready = req_ready_r;

  if (OUT_STAGES == 0) begin : g_pipe0
    logic [DWIDTH-1:0] hold_r;

    // Keeps the last result so rsp_data does not follow RMW reads.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        hold_r <= {DWIDTH{1'b0}};
      end else if (vld0_r) begin
        hold_r <= s0_data_s;
      end
    end

    assign bus.rsp_valid = vld0_r;
    assign bus.rsp_data  = vld0_r ? s0_data_s : hold_r;
    assign bus.busy      = (state_r != IDLE) | vld0_r;
  end else begin : g_pipeN
    logic [OUT_STAGES:1] pv_r;
    logic [DWIDTH-1:0]   pd_r  [1:OUT_STAGES];
    logic [OUT_STAGES:1] vin_s;
    logic [DWIDTH-1:0]   din_s [1:OUT_STAGES];

    // Stage inputs: stage 1 from the array register, later stages chained.
    always_comb begin
      vin_s[1] = vld0_r;
      din_s[1] = s0_data_s;
      for (int k = 2; k <= OUT_STAGES; k++) begin
        vin_s[k] = pv_r[k-1];
        din_s[k] = pd_r[k-1];
      end
    end

    // Output stages; data only advances with a valid so the last one holds.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        for (int k = 1; k <= OUT_STAGES; k++) begin
          pv_r[k] <= 1'b0;
          pd_r[k] <= {DWIDTH{1'b0}};
        end
      end else begin
        for (int k = 1; k <= OUT_STAGES; k++) begin
          pv_r[k] <= vin_s[k];
          if (vin_s[k]) begin
            pd_r[k] <= din_s[k];
          end
        end
      end
    end

    assign bus.rsp_valid = pv_r[OUT_STAGES];
    assign bus.rsp_data  = pd_r[OUT_STAGES];
    assign bus.busy      = (state_r != IDLE) | vld0_r | (|pv_r);
  end

endmodule

// File: tb/tb_spram_lane_rmw.sv
// -----------------------------------------------------------------------------
// tb_spram_lane_rmw
// Directed self-checking bench for spram_lane_rmw (NUM_WORDS=2000,
// OUT_STAGES=1). Inputs change 1 time unit after the rising edge; outputs are
// sampled at the same point.
// -----------------------------------------------------------------------------
module tb_spram_lane_rmw;

  localparam int AW = 11;
  localparam int DW = 40;
  localparam int LN = 5;
  localparam int NW = 2000;
  localparam int OS = 1;
  localparam int RD_LAT = 1 + OS;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;
  logic [DW-1:0] b2b_exp [0:15];

  always #5 clk = ~clk;

  spram_lane_rmw_if #(.AWIDTH(AW), .DWIDTH(DW), .LANES(LN)) bus ();

  spram_lane_rmw #(
    .AWIDTH(AW), .NUM_WORDS(NW), .DWIDTH(DW), .LANES(LN), .OUT_STAGES(OS)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.req_wren  = 1'b0;
    bus.req_mask  = 5'b00000;
    bus.req_addr  = 11'h000;
    bus.req_data  = 40'h00_0000_0000;
  endtask

  task automatic drive_req(input logic wren, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [LN-1:0] m);
    bus.req_valid = 1'b1;
    bus.req_wren  = wren;
    bus.req_mask  = m;
    bus.req_addr  = a;
    bus.req_data  = d;
  endtask

  // Issue one write and wait (bounded) until the block accepts again.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [LN-1:0] m);
    drive_req(1'b1, a, d, m);
    step();
    idle_inputs();
    for (int i = 0; i < 4 && !bus.req_ready; i++) step();
    tests_run++;
    if (bus.req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_ready_timeout: req_ready=%b required 1", bus.req_ready);
    end
  endtask

  // Issue one read; report cycle of rsp_valid (1 = cycle after accept).
  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                         output int lat);
    drive_req(1'b0, a, 40'h00_0000_0000, 5'b00000);
    step();
    idle_inputs();
    lat = -1;
    d   = 40'h00_0000_0000;
    for (int i = 1; i <= 6; i++) begin
      if (bus.rsp_valid === 1'b1) begin
        lat = i;
        d   = bus.rsp_data;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    step();
    step();
    tests_run++;
    if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b required 1", bus.req_ready); end
    tests_run++;
    if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b required 0", bus.rsp_valid); end
    tests_run++;
    if (bus.rsp_data !== 40'h00_0000_0000) begin tests_failed++; $display("FAIL reset_rsp_data: got %h required 0", bus.rsp_data); end
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_full_write_read();
    do_write(11'h000, 40'hAB_CDEF_0123, 5'b11111);
    drive_req(1'b0, 11'h000, 40'h00_0000_0000, 5'b00000);
    step();
    idle_inputs();
    tests_run++;
    if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rd_t1_valid: got %b required 0", bus.rsp_valid); end
    tests_run++;
    if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL rd_t1_busy: got %b required 1", bus.busy); end
    step();
    tests_run++;
    if (bus.rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL rd_t2_valid: got %b required 1", bus.rsp_valid); end
    tests_run++;
    if (bus.rsp_data !== 40'hAB_CDEF_0123) begin tests_failed++; $display("FAIL rd_t2_data: got %h required abcdef0123", bus.rsp_data); end
    step();
    tests_run++;
    if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rd_t3_valid: got %b required 0", bus.rsp_valid); end
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL rd_t3_busy: got %b required 0", bus.busy); end
  endtask

  task automatic test_partial_write();
    logic [DW-1:0] d;
    int            lat;
    do_write(11'h010, 40'h11_2233_4455, 5'b11111);
    drive_req(1'b1, 11'h010, 40'hFF_FFFF_FFFF, 5'b00101);
    step();
    idle_inputs();
    tests_run++;
    if (bus.req_ready !== 1'b0) begin tests_failed++; $display("FAIL pw_t1_ready: got %b required 0", bus.req_ready); end
    tests_run++;
    if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL pw_t1_busy: got %b required 1", bus.busy); end
    tests_run++;
    if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL pw_t1_rsp_valid: got %b required 0", bus.rsp_valid); end
    step();
    tests_run++;
    if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL pw_t2_ready: got %b required 1", bus.req_ready); end
    tests_run++;
    if (bus.rsp_data !== 40'hAB_CDEF_0123) begin tests_failed++; $display("FAIL pw_rsp_data_held: got %h required abcdef0123", bus.rsp_data); end
    do_read(11'h010, d, lat);
    tests_run++;
    if (lat !== RD_LAT) begin tests_failed++; $display("FAIL pw_read_latency: got %0d required %0d", lat, RD_LAT); end
    tests_run++;
    if (d !== 40'h11_22FF_44FF) begin tests_failed++; $display("FAIL pw_read_data: got %h required 1122ff44ff", d); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      b2b_exp[i] = 40'h00_5A5A_0000 + (40'(i) * 40'h01_0001_0001);
      do_write(11'(i), b2b_exp[i], 5'b11111);
    end
    for (int c = 0; c < 20; c++) begin
      if (c < 16) drive_req(1'b0, 11'(c), 40'h00_0000_0000, 5'b00000);
      else idle_inputs();
      step();
      if (c >= 1 && c <= 16) begin
        tests_run++;
        if (bus.rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_valid[%0d]: got %b required 1", c - 1, bus.rsp_valid); end
        tests_run++;
        if (bus.rsp_data !== b2b_exp[c-1]) begin tests_failed++; $display("FAIL b2b_data[%0d]: got %h required %h", c - 1, bus.rsp_data, b2b_exp[c-1]); end
      end else begin
        tests_run++;
        if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_gap[%0d]: got %b required 0", c, bus.rsp_valid); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_zero_mask();
    logic [DW-1:0] d;
    int            lat;
    do_write(11'h020, 40'h12_3456_789A, 5'b11111);
    drive_req(1'b1, 11'h020, 40'hFF_FFFF_FFFF, 5'b00000);
    step();
    idle_inputs();
    tests_run++;
    if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL zm_ready: got %b required 1", bus.req_ready); end
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL zm_busy: got %b required 0", bus.busy); end
    do_read(11'h020, d, lat);
    tests_run++;
    if (lat !== RD_LAT) begin tests_failed++; $display("FAIL zm_read_latency: got %0d required %0d", lat, RD_LAT); end
    tests_run++;
    if (d !== 40'h12_3456_789A) begin tests_failed++; $display("FAIL zm_read_data: got %h required 123456789a", d); end
    step();
  endtask

  task automatic test_out_of_range();
    logic [DW-1:0] d;
    int            lat;
    do_read(11'h7D0, d, lat);
    tests_run++;
    if (lat !== RD_LAT) begin tests_failed++; $display("FAIL oor_read_latency: got %0d required %0d", lat, RD_LAT); end
    tests_run++;
    if (d !== 40'h00_0000_0000) begin tests_failed++; $display("FAIL oor_read_data: got %h required 0", d); end
    do_write(11'h7D0, 40'hDE_AD00_BEEF, 5'b11111);
    do_read(11'h000, d, lat);
    tests_run++;
    if (d !== b2b_exp[0]) begin tests_failed++; $display("FAIL oor_full_write_alias: got %h required %h", d, b2b_exp[0]); end
    step();
    drive_req(1'b1, 11'h7D0, 40'hFF_FFFF_FFFF, 5'b01010);
    step();
    idle_inputs();
    tests_run++;
    if (bus.req_ready !== 1'b0) begin tests_failed++; $display("FAIL oor_rmw_ready: got %b required 0", bus.req_ready); end
    step();
    do_read(11'h000, d, lat);
    tests_run++;
    if (d !== b2b_exp[0]) begin tests_failed++; $display("FAIL oor_rmw_alias: got %h required %h", d, b2b_exp[0]); end
    step();
  endtask

  task automatic test_reset_mid_rmw();
    logic [DW-1:0] d;
    int            lat;
    do_write(11'h030, 40'h0F_1E2D_3C4B, 5'b11111);
    drive_req(1'b1, 11'h030, 40'hAA_AAAA_AAAA, 5'b11110);
    step();
    idle_inputs();
    tests_run++;
    if (bus.req_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_rmw_state: req_ready=%b required 0", bus.req_ready); end
    resetn = 1'b0;
    #1;
    tests_run++;
    if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_rmw_ready: got %b required 1", bus.req_ready); end
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL rst_rmw_busy: got %b required 0", bus.busy); end
    for (int i = 0; i < 2; i++) begin
      step();
      tests_run++;
      if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_during_valid[%0d]: got %b required 0", i, bus.rsp_valid); end
    end
    resetn = 1'b1;
    step();
    tests_run++;
    if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_after_valid: got %b required 0", bus.rsp_valid); end
    tests_run++;
    if (bus.rsp_data !== 40'h00_0000_0000) begin tests_failed++; $display("FAIL rst_after_data: got %h required 0", bus.rsp_data); end
    do_read(11'h030, d, lat);
    tests_run++;
    if (lat !== RD_LAT) begin tests_failed++; $display("FAIL rst_read_latency: got %0d required %0d", lat, RD_LAT); end
    tests_run++;
    if (d !== 40'h0F_1E2D_3C4B) begin tests_failed++; $display("FAIL rst_read_data: got %h required 0f1e2d3c4b", d); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_full_write_read();
    test_partial_write();
    test_back_to_back();
    test_zero_mask();
    test_out_of_range();
    test_reset_mid_rmw();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
